// File: rtl/ahb3_pkg.sv
// Shared AHB-lite definitions: transfer/size/response encodings (matching
// amba3.svh), the SRAM model FSM state type and a byte-lane enable helper.
package ahb3_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  // Little-endian lane enables for a transfer of the given size at addr[1:0].
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = 4'b0011 << addr_lo;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb3_bytelane_dec.sv
// Byte-lane decoder for 32-bit AHB slaves: size + addr[1:0] -> lane enables
// and a misalignment flag (odd halfword, word not on a 4-byte boundary).
module ahb3_bytelane_dec (
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misalign
);
  import ahb3_pkg::*;

  // Purely combinational lane and alignment decode.
  always_comb begin
    be       = byte_en(size, addr_lo);
    misalign = 1'b0;
    case (size)
      HSIZE_HALF: misalign = addr_lo[0];
      HSIZE_WORD: misalign = (addr_lo != 2'b00);
      default:    misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahb3_sram_model.sv
// AHB-lite slave SRAM model: word-organised RAM with byte/half/word access,
// per-beat decode and two-cycle ERROR for out-of-window or misaligned beats.
// Build option: define AHB3_SRAM_WAIT_EN to insert WAIT_CYCLES wait states
// per OK data phase; otherwise every OK transfer is zero-wait.
module ahb3_sram_model #(
  parameter int unsigned ADDRSIZE    = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int          tpd         = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        HSEL_i,
  input  logic [31:0] HADDR_i,
  input  logic        HWRITE_i,
  input  logic [2:0]  HSIZE_i,
  input  logic [2:0]  HBURST_i,
  input  logic [3:0]  HPROT_i,
  input  logic [1:0]  HTRANS_i,
  input  logic        HMASTLOCK_i,
  input  logic [31:0] HWDATA_i,
  output logic        HREADY_o,
  output logic        HRESP_o,
  output logic [31:0] HRDATA_o
);
  import ahb3_pkg::*;

  localparam int unsigned WIDX = ADDRSIZE - 2;

  logic [31:0] mem [0:(1 << WIDX) - 1];

  sram_state_e     state;
  logic [WIDX-1:0] word_q;
  logic [3:0]      be_q;
  logic            wr_q;

`ifdef AHB3_SRAM_WAIT_EN
  logic [3:0]      wait_cnt;
`endif

  htrans_e   trans;
  logic      accept;
  logic      err_d;
  logic      misalign_d;
  logic [3:0] be_d;

  // Burst type, protection, lock and the simulation delay do not affect decode.
  logic unused_ignored;
  assign unused_ignored = ^{32'(tpd), 32'(WAIT_CYCLES), HBURST_i, HPROT_i, HMASTLOCK_i};

  ahb3_bytelane_dec u_dec (
    .size     (HSIZE_i),
    .addr_lo  (HADDR_i[1:0]),
    .be       (be_d),
    .misalign (misalign_d)
  );

  assign trans  = htrans_e'(HTRANS_i);
  assign accept = HSEL_i && HREADY_o && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
  assign err_d  = (HADDR_i[31:ADDRSIZE] != BASE_ADDR[31:ADDRSIZE])
               || (HSIZE_i > HSIZE_WORD)
               || misalign_d;

  // Transfer FSM: DATA and ERR2 accept the next address phase like IDLE,
  // so pipelined beats run back-to-back; ready/response are registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      HREADY_o <= 1'b1;
      HRESP_o  <= HRESP_OKAY;
      word_q   <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
`ifdef AHB3_SRAM_WAIT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
`ifdef AHB3_SRAM_WAIT_EN
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state    <= ST_DATA;
            HREADY_o <= 1'b1;
            HRESP_o  <= HRESP_OKAY;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`endif
        ST_ERR1: begin
          state    <= ST_ERR2;
          HREADY_o <= 1'b1;
          HRESP_o  <= HRESP_ERROR;
        end
        default: begin
          if (accept) begin
            word_q <= HADDR_i[ADDRSIZE-1:2];
            be_q   <= be_d;
            wr_q   <= HWRITE_i;
            if (err_d) begin
              state    <= ST_ERR1;
              HREADY_o <= 1'b0;
              HRESP_o  <= HRESP_ERROR;
            end
`ifdef AHB3_SRAM_WAIT_EN
            else if (WAIT_CYCLES > 0) begin
              // Counter starts at W-1 so exactly W WAIT cycles precede DATA.
              state    <= ST_WAIT;
              HREADY_o <= 1'b0;
              HRESP_o  <= HRESP_OKAY;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
`endif
            else begin
              state    <= ST_DATA;
              HREADY_o <= 1'b1;
              HRESP_o  <= HRESP_OKAY;
            end
          end else begin
            state    <= ST_IDLE;
            HREADY_o <= 1'b1;
            HRESP_o  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Commit enabled lanes at the edge closing a write data phase; a reset on
  // that edge discards the pending write.
  always_ff @(posedge clk) begin
    if (resetn && state == ST_DATA && wr_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem[word_q][8*i +: 8] <= HWDATA_i[8*i +: 8];
      end
    end
  end

  // Read data is the full addressed word during an OK read data phase, else zero.
  assign HRDATA_o = (state == ST_DATA && !wr_q) ? mem[word_q] : '0;

endmodule

// File: tb/tb_ahb3_sram_model.sv
// Bench for ahb3_sram_model: table of AHB beats with expected responses,
// a scoreboard queue filled at address acceptance and drained by a
// data-phase monitor, plus a hand-written mid-transfer reset sequence.
module tb_ahb3_sram_model;
  import ahb3_pkg::*;

`ifdef AHB3_SRAM_WAIT_EN
  localparam int unsigned EXP_W = 3;
`else
  localparam int unsigned EXP_W = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        HSEL_i = 1'b0;
  logic [31:0] HADDR_i = '0;
  logic        HWRITE_i = 1'b0;
  logic [2:0]  HSIZE_i = '0;
  logic [2:0]  HBURST_i = 3'b001;
  logic [3:0]  HPROT_i = 4'b0011;
  logic [1:0]  HTRANS_i = 2'b00;
  logic        HMASTLOCK_i = 1'b0;
  logic [31:0] HWDATA_i = '0;
  logic        HREADY_o;
  logic        HRESP_o;
  logic [31:0] HRDATA_o;

  int n_tests = 0;
  int n_fail  = 0;

  ahb3_sram_model #(
    .ADDRSIZE    (10),
    .BASE_ADDR   (32'h0),
    .WAIT_CYCLES (3),
    .tpd         (0)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .HSEL_i      (HSEL_i),
    .HADDR_i     (HADDR_i),
    .HWRITE_i    (HWRITE_i),
    .HSIZE_i     (HSIZE_i),
    .HBURST_i    (HBURST_i),
    .HPROT_i     (HPROT_i),
    .HTRANS_i    (HTRANS_i),
    .HMASTLOCK_i (HMASTLOCK_i),
    .HWDATA_i    (HWDATA_i),
    .HREADY_o    (HREADY_o),
    .HRESP_o     (HRESP_o),
    .HRDATA_o    (HRDATA_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic vec_t mk(input string nm, input logic sel, input logic [1:0] tr,
                              input logic wr, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic er, input logic [31:0] rd);
    vec_t v;
    v.name = nm; v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz;
    v.addr = a; v.wdata = wd; v.err = er; v.rdata = rd;
    return v;
  endfunction

  // Present one address phase, hold it until HREADY_o, then drive its write data.
  task automatic drive(input vec_t v);
    int unsigned n;
    HSEL_i   = v.sel;
    HTRANS_i = v.trans;
    HWRITE_i = v.wr;
    HSIZE_i  = v.size;
    HADDR_i  = v.addr;
    n = 0;
    @(negedge clk);
    while (!HREADY_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!HREADY_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s/accept: HREADY_o still %b after %0d cycles, expected 1", v.name, HREADY_o, n);
      finish_tb();
    end
    if (v.sel && v.trans[1]) exp_q.push_back('{v.name, v.err, v.rdata});
    @(posedge clk);
    #1;
    HWDATA_i = (v.sel && v.trans[1] && v.wr) ? v.wdata : 32'hBAD0_BAD0;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) drive(tbl[i]);
  endtask

  // Data-phase monitor: counts stall cycles and compares the completing beat.
  logic        dp_active = 1'b0;
  int unsigned low_cnt = 0;
  logic        low_resp = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    if (!resetn) begin
      dp_active = 1'b0;
      low_cnt   = 0;
      exp_q.delete();
    end else begin
      if (dp_active) begin
        if (!HREADY_o) begin
          low_cnt++;
          if (low_cnt == 1) low_resp = HRESP_o;
        end else begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: data phase completed with no expected entry");
          end else begin
            e = exp_q.pop_front();
            check({e.name, "/stall"}, low_cnt, e.err ? 1 : EXP_W);
            check({e.name, "/resp"}, {31'b0, HRESP_o}, {31'b0, e.err});
            if (low_cnt > 0) check({e.name, "/resp_stall"}, {31'b0, low_resp}, {31'b0, e.err});
            check({e.name, "/rdata"}, HRDATA_o, e.rdata);
          end
          low_cnt = 0;
        end
      end else begin
        check("idle/ready", {31'b0, HREADY_o}, 32'd1);
        check("idle/resp", {31'b0, HRESP_o}, 32'd0);
        check("idle/rdata", HRDATA_o, 32'd0);
      end
      if (HREADY_o) dp_active = HSEL_i && HTRANS_i[1];
    end
  end

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_tb();
  end

  localparam logic [1:0] NS = 2'b10, SQ = 2'b11, BZ = 2'b01, ID = 2'b00;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  initial begin
    int split;
    // Phase 1
    tbl.push_back(mk("w_word10",     1, NS, 1, SW, 32'h10, 32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mk("r_word10",     1, NS, 0, SW, 32'h10, 32'h0,        0, 32'hDEADBEEF));
    tbl.push_back(mk("w_byte11",     1, NS, 1, SB, 32'h11, 32'h1122AA33, 0, 32'h0));
    tbl.push_back(mk("r_after_byte", 1, NS, 0, SW, 32'h10, 32'h0,        0, 32'hDEADAAEF));
    tbl.push_back(mk("w_half13_err", 1, NS, 1, SH, 32'h13, 32'hFFFFFFFF, 1, 32'h0));
    tbl.push_back(mk("r_unchanged",  1, NS, 0, SW, 32'h10, 32'h0,        0, 32'hDEADAAEF));
    tbl.push_back(mk("r_oow",        1, NS, 0, SW, 32'h400, 32'h0,       1, 32'h0));
    tbl.push_back(mk("r_oow_hi",     1, NS, 0, SW, 32'h80000010, 32'h0,  1, 32'h0));
    tbl.push_back(mk("idle_sel",     1, ID, 1, SW, 32'h10, 32'h0,        0, 32'h0));
    tbl.push_back(mk("burst0",       1, NS, 1, SW, 32'h20, 32'hA0A00020, 0, 32'h0));
    tbl.push_back(mk("burst1",       1, SQ, 1, SW, 32'h24, 32'hA1A10024, 0, 32'h0));
    tbl.push_back(mk("busy",         1, BZ, 1, SW, 32'h28, 32'h0,        0, 32'h0));
    tbl.push_back(mk("burst2",       1, SQ, 1, SW, 32'h28, 32'hA2A20028, 0, 32'h0));
    tbl.push_back(mk("burst3",       1, SQ, 1, SW, 32'h2C, 32'hA3A3002C, 0, 32'h0));
    tbl.push_back(mk("rb0",          1, NS, 0, SW, 32'h20, 32'h0,        0, 32'hA0A00020));
    tbl.push_back(mk("rb1",          1, SQ, 0, SW, 32'h24, 32'h0,        0, 32'hA1A10024));
    tbl.push_back(mk("rb2",          1, SQ, 0, SW, 32'h28, 32'h0,        0, 32'hA2A20028));
    tbl.push_back(mk("rb3",          1, SQ, 0, SW, 32'h2C, 32'h0,        0, 32'hA3A3002C));
    tbl.push_back(mk("w_half22",     1, NS, 1, SH, 32'h22, 32'hBEEF1234, 0, 32'h0));
    tbl.push_back(mk("r_half22",     1, NS, 0, SW, 32'h20, 32'h0,        0, 32'hBEEF0020));
    tbl.push_back(mk("r_byte2d",     1, NS, 0, SB, 32'h2D, 32'h0,        0, 32'hA3A3002C));
    tbl.push_back(mk("w_word_mis",   1, NS, 1, SW, 32'h12, 32'h0,        1, 32'h0));
    tbl.push_back(mk("w_byte13",     1, NS, 1, SB, 32'h13, 32'h77665544, 0, 32'h0));
    tbl.push_back(mk("r_byte13",     1, NS, 0, SW, 32'h10, 32'h0,        0, 32'h77ADAAEF));
    tbl.push_back(mk("r_size3",      1, NS, 0, 3'd3, 32'h30, 32'h0,      1, 32'h0));
    tbl.push_back(mk("w_word30",     1, NS, 1, SW, 32'h30, 32'h12345678, 0, 32'h0));
    tbl.push_back(mk("nosel",        0, NS, 1, SW, 32'h30, 32'h0,        0, 32'h0));
    split = tbl.size();
    // Phase 2, after the mid-transfer reset
    tbl.push_back(mk("r_word30_kept", 1, NS, 0, SW, 32'h30, 32'h0,       0, 32'h12345678));
    tbl.push_back(mk("r_word10_kept", 1, NS, 0, SW, 32'h10, 32'h0,       0, 32'h77ADAAEF));
    tbl.push_back(mk("flush",         0, ID, 0, SW, 32'h0,  32'h0,       0, 32'h0));

    repeat (3) @(posedge clk);
    #1;
    check("reset/ready", {31'b0, HREADY_o}, 32'd1);
    check("reset/resp",  {31'b0, HRESP_o},  32'd0);
    check("reset/rdata", HRDATA_o, 32'd0);
    resetn = 1'b1;

    run_range(0, split);

    // Write to 0x30 whose data phase is cut short by reset: must not commit.
    HSEL_i = 1'b1; HTRANS_i = NS; HWRITE_i = 1'b1; HSIZE_i = SW; HADDR_i = 32'h30;
    @(negedge clk);
    check("rst_mid/accept_ready", {31'b0, HREADY_o}, 32'd1);
    @(posedge clk);
    #1;
    HWDATA_i = 32'h0BAD0030;
    HSEL_i   = 1'b0;
    HTRANS_i = ID;
    resetn   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid/ready", {31'b0, HREADY_o}, 32'd1);
    check("rst_mid/resp",  {31'b0, HRESP_o},  32'd0);
    resetn = 1'b1;

    run_range(split, tbl.size());
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 32'd0);
    finish_tb();
  end

endmodule
